// File: rtl/fifo_pkg.sv
// Shared widths and beat-slice helper for the FIFO-to-AXI-Stream read path.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 128;
    localparam int FIFO_AXIS_WIDTH = 32;
    localparam int FIFO_RATIO      = FIFO_DATA_WIDTH / FIFO_AXIS_WIDTH;
    localparam int FIFO_BEAT_W     = $clog2(FIFO_RATIO);

    // Beats go out most-significant slice first, so beat 0 sits at the top of the word.
    function automatic int beat_lsb(input int beat, input int data_w, input int axis_w);
        return data_w - (beat + 1) * axis_w;
    endfunction

endpackage

// File: rtl/axis_width_down.sv
// Hold register plus beat counter: one wide valid/ready word in, RATIO narrow beats out.
module axis_width_down
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int AXIS_WIDTH = FIFO_AXIS_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AXIS_WIDTH-1:0] out_data,
    output logic                  out_last_beat
);

    localparam int RATIO  = DATA_WIDTH / AXIS_WIDTH;
    localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic                  beat_done;
    logic                  word_accept;

    assign out_valid     = hold_valid_q;
    assign out_last_beat = hold_valid_q & (beat_cnt_q == LAST_BEAT);
    assign beat_done     = hold_valid_q & out_ready;
    // Ready looks through to out_ready so a new word lands on the same edge the last beat leaves.
    assign in_ready      = ~reset & (~hold_valid_q | (beat_done & (beat_cnt_q == LAST_BEAT)));
    assign word_accept   = in_valid & in_ready;
    assign out_data      = hold_q[beat_lsb(int'(beat_cnt_q), DATA_WIDTH, AXIS_WIDTH) +: AXIS_WIDTH];

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        beat_cnt_d   = beat_cnt_q;
        if (beat_done) begin
            if (beat_cnt_q == LAST_BEAT) begin
                hold_valid_d = 1'b0;
            end else begin
                beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end
        end
        if (word_accept) begin
            hold_d       = in_data;
            hold_valid_d = 1'b1;
            beat_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            beat_cnt_q   <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

endmodule

// File: rtl/fifo_axis_tx.sv
// Drains FIFO words into AXI-Stream beats and frames them into packets of pkt_blocks words.
module fifo_axis_tx
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = FIFO_DATA_WIDTH,
    parameter int AXIS_WIDTH    = FIFO_AXIS_WIDTH,
    parameter int BLK_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fifo_read_tvalid,
    output logic                     fifo_read_tready,
    input  logic [DATA_WIDTH-1:0]    fifo_rdata,
    input  logic [BLK_CNT_WIDTH-1:0] pkt_blocks,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [AXIS_WIDTH-1:0]    m_axis_tdata,
    output logic [AXIS_WIDTH/8-1:0]  m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic                     busy
);

    logic [BLK_CNT_WIDTH-1:0] blk_cnt_q, blk_cnt_d;
    logic [BLK_CNT_WIDTH-1:0] blk_last_q, blk_last_d;
    logic                     in_pkt_q, in_pkt_d;
    logic                     last_beat;
    logic                     word_accept;
    logic                     tlast_done;

    axis_width_down #(
        .DATA_WIDTH (DATA_WIDTH),
        .AXIS_WIDTH (AXIS_WIDTH)
    ) u_width_down (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (fifo_read_tvalid),
        .in_ready      (fifo_read_tready),
        .in_data       (fifo_rdata),
        .out_valid     (m_axis_tvalid),
        .out_ready     (m_axis_tready),
        .out_data      (m_axis_tdata),
        .out_last_beat (last_beat)
    );

    assign word_accept  = fifo_read_tvalid & fifo_read_tready;
    assign m_axis_tlast = last_beat & in_pkt_q & (blk_cnt_q == blk_last_q);
    assign tlast_done   = m_axis_tlast & m_axis_tready;
    assign m_axis_tkeep = '1;
    assign busy         = in_pkt_q;

    // A word arriving on the TLAST handshake opens the next packet rather than extending this one.
    always_comb begin
        blk_cnt_d  = blk_cnt_q;
        blk_last_d = blk_last_q;
        in_pkt_d   = in_pkt_q;
        if (tlast_done) begin
            in_pkt_d = 1'b0;
        end
        if (word_accept) begin
            if (!in_pkt_q || tlast_done) begin
                blk_last_d = (pkt_blocks == '0) ? '0 : pkt_blocks - BLK_CNT_WIDTH'(1);
                blk_cnt_d  = '0;
                in_pkt_d   = 1'b1;
            end else begin
                blk_cnt_d = blk_cnt_q + BLK_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blk_cnt_q  <= '0;
            blk_last_q <= '0;
            in_pkt_q   <= 1'b0;
        end else begin
            blk_cnt_q  <= blk_cnt_d;
            blk_last_q <= blk_last_d;
            in_pkt_q   <= in_pkt_d;
        end
    end

endmodule

// File: tb/tb_fifo_axis_tx.sv
// Scoreboard bench for fifo_axis_tx: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_fifo_axis_tx;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic         clk;
    logic         reset;
    logic         fifo_read_tvalid;
    logic         fifo_read_tready;
    logic [127:0] fifo_rdata;
    logic [15:0]  pkt_blocks;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [31:0]  m_axis_tdata;
    logic [3:0]   m_axis_tkeep;
    logic         m_axis_tlast;
    logic         busy;

    logic [127:0] fifo_q[$];
    beat_t        sb[$];
    int           assert_count;
    int           fail_count;
    bit           rand_ready;
    bit           rand_fifo;
    bit           ready_fixed;
    bit           accepted;
    bit           prev_stall;
    logic [31:0]  prev_data;
    logic         prev_last;

    fifo_axis_tx dut (
        .clk              (clk),
        .reset            (reset),
        .fifo_read_tvalid (fifo_read_tvalid),
        .fifo_read_tready (fifo_read_tready),
        .fifo_rdata       (fifo_rdata),
        .pkt_blocks       (pkt_blocks),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tkeep     (m_axis_tkeep),
        .m_axis_tlast     (m_axis_tlast),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock: retire the word the DUT took, then present the next FIFO head and tready.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (accepted) void'(fifo_q.pop_front());
        fifo_read_tvalid = (fifo_q.size() > 0) && (rand_fifo ? ($urandom_range(0, 1) == 1) : 1'b1);
        fifo_rdata       = (fifo_q.size() > 0) ? fifo_q[0] : 128'h0;
        m_axis_tready    = rand_ready ? ($urandom_range(0, 1) == 1) : ready_fixed;
        @(negedge clk);
        #1;
        accepted = fifo_read_tvalid && fifo_read_tready;
    endtask

    task automatic pushWord(input logic [127:0] w, input bit last);
        beat_t b;
        fifo_q.push_back(w);
        for (int k = 0; k < 4; k++) begin
            b.data = w[127 - 32*k -: 32];
            b.last = last && (k == 3);
            sb.push_back(b);
        end
    endtask

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while ((sb.size() > 0) && (n < bound)) begin
            applyStimulus();
            n++;
        end
        checkOutput(name, 128'(sb.size()), 128'd0);
    endtask

    // Monitor: every handshake consumes one scoreboard entry; stalled beats must hold still.
    always @(negedge clk) begin
        beat_t exp_b;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_tvalid", 128'(m_axis_tvalid), 128'd1);
                checkOutput("stall_tdata", 128'(m_axis_tdata), 128'(prev_data));
                checkOutput("stall_tlast", 128'(m_axis_tlast), 128'(prev_last));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    assert_count++;
                    fail_count++;
                    $display("[TB] FAIL unexpected_beat: got tdata %0h, expected no beat at %0t", m_axis_tdata, $time);
                end else begin
                    exp_b = sb.pop_front();
                    checkOutput("beat_tdata", 128'(m_axis_tdata), 128'(exp_b.data));
                    checkOutput("beat_tlast", 128'(m_axis_tlast), 128'(exp_b.last));
                    checkOutput("beat_tkeep", 128'(m_axis_tkeep), 128'hF);
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    initial begin
        #(10 * 90000);
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        beat_t b;
        assert_count     = 0;
        fail_count       = 0;
        rand_ready       = 1'b0;
        rand_fifo        = 1'b0;
        ready_fixed      = 1'b1;
        accepted         = 1'b0;
        prev_stall       = 1'b0;
        reset            = 1'b1;
        fifo_read_tvalid = 1'b0;
        fifo_rdata       = 128'h0;
        pkt_blocks       = 16'd1;
        m_axis_tready    = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_fifo_tready", 128'(fifo_read_tready), 128'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_tvalid", 128'(m_axis_tvalid), 128'd0);
        checkOutput("rst_tlast", 128'(m_axis_tlast), 128'd0);
        checkOutput("rst_busy", 128'(busy), 128'd0);
        checkOutput("idle_fifo_tready", 128'(fifo_read_tready), 128'd1);

        // Test 1: single-word packet, hand-split beats
        $display("[TB] test 1: single word packet");
        pkt_blocks = 16'd1;
        fifo_q.push_back(128'h00112233_44556677_8899AABB_CCDDEEFF);
        b = '{32'h00112233, 1'b0}; sb.push_back(b);
        b = '{32'h44556677, 1'b0}; sb.push_back(b);
        b = '{32'h8899AABB, 1'b0}; sb.push_back(b);
        b = '{32'hCCDDEEFF, 1'b1}; sb.push_back(b);
        applyStimulus();
        checkOutput("t1_first_tvalid_latency", 128'(m_axis_tvalid), 128'd0);
        applyStimulus();
        checkOutput("t1_busy_during", 128'(busy), 128'd1);
        drain("t1_drain", 20);
        applyStimulus();
        checkOutput("t1_busy_after", 128'(busy), 128'd0);
        checkOutput("t1_tvalid_after", 128'(m_axis_tvalid), 128'd0);

        // Test 2: six preloaded words, two 3-word packets, no bubbles
        $display("[TB] test 2: back-to-back packets");
        pkt_blocks = 16'd3;
        for (int i = 0; i < 6; i++)
            pushWord({8'(i), 24'hA0A0A0, 32'h11111111 * (i + 1), 32'hDEADBEEF, 32'h01234567 + 32'(i)}, (i % 3) == 2);
        applyStimulus();
        for (int k = 0; k < 24; k++) begin
            applyStimulus();
            checkOutput("t2_no_bubble", 128'(m_axis_tvalid), 128'd1);
            checkOutput("t2_fifo_tready", 128'(fifo_read_tready), 128'((k % 4) == 3));
        end
        drain("t2_drain", 10);
        applyStimulus();

        // Test 3: random backpressure and FIFO gaps, 5-word packets
        $display("[TB] test 3: random traffic");
        pkt_blocks = 16'd5;
        rand_ready = 1'b1;
        rand_fifo  = 1'b1;
        for (int i = 0; i < 600; i++)
            pushWord({$urandom, $urandom, $urandom, $urandom}, (i % 5) == 4);
        drain("t3_drain", 30000);
        rand_ready = 1'b0;
        rand_fifo  = 1'b0;
        ready_fixed = 1'b1;
        repeat (3) applyStimulus();
        checkOutput("t3_busy_after", 128'(busy), 128'd0);

        // Test 4: pkt_blocks=0 behaves as one word per packet
        $display("[TB] test 4: pkt_blocks zero");
        pkt_blocks = 16'd0;
        for (int i = 0; i < 6; i++)
            pushWord({32'hC0DE0000 + 32'(i), 32'h5A5A5A5A, 32'(i * 7), 32'hFFFF0000 | 32'(i)}, 1'b1);
        drain("t4_drain", 100);
        applyStimulus();
        checkOutput("t4_busy_after", 128'(busy), 128'd0);

        // Test 5: reset after two beats of the first word of a 2-word packet
        $display("[TB] test 5: mid-packet reset");
        pkt_blocks = 16'd2;
        fifo_q.push_back(128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004);
        b = '{32'hAAAA0001, 1'b0}; sb.push_back(b);
        b = '{32'hAAAA0002, 1'b0}; sb.push_back(b);
        drain("t5_two_beats", 20);
        checkOutput("t5_busy_before", 128'(busy), 128'd1);
        @(posedge clk);
        #1;
        accepted      = 1'b0;
        ready_fixed   = 1'b0;
        m_axis_tready = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("t5_fifo_tready_in_reset", 128'(fifo_read_tready), 128'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("t5_tvalid_after_reset", 128'(m_axis_tvalid), 128'd0);
        checkOutput("t5_busy_after_reset", 128'(busy), 128'd0);
        ready_fixed = 1'b1;
        pkt_blocks  = 16'd1;
        pushWord(128'hBBBB0001_BBBB0002_BBBB0003_BBBB0004, 1'b1);
        drain("t5_fresh_packet", 20);
        applyStimulus();
        checkOutput("t5_busy_end", 128'(busy), 128'd0);

        // Test 6: FIFO runs dry between the two words of a packet
        $display("[TB] test 6: FIFO gap inside packet");
        pkt_blocks = 16'd2;
        pushWord(128'h66660001_66660002_66660003_66660004, 1'b0);
        drain("t6_word1", 20);
        for (int k = 0; k < 10; k++) begin
            applyStimulus();
            checkOutput("t6_gap_tvalid", 128'(m_axis_tvalid), 128'd0);
            checkOutput("t6_gap_busy", 128'(busy), 128'd1);
        end
        pushWord(128'h77770001_77770002_77770003_77770004, 1'b1);
        drain("t6_word2", 20);
        applyStimulus();
        checkOutput("t6_busy_end", 128'(busy), 128'd0);

        repeat (2) applyStimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
